// File: rtl/seg7_anim_engine.sv
// seg7_anim_engine
// Clocked frame sequencer for one 7-segment digit. It supports eight pattern
// modes, a programmable frame period, loop or one-shot playback, pause, and a
// one-cycle done pulse. All outputs come straight from flops.
// Segment bit order: 0 top, 1 upper-right, 2 lower-right, 3 bottom,
// 4 lower-left, 5 upper-left, 6 middle. A 1 lights the segment.
module seg7_anim_engine #(
    parameter int unsigned TICK_W    = 24,
    parameter int unsigned DIGIT_MAX = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TICK_W-1:0] period,
    input  logic [2:0]        mode,
    input  logic              oneshot,
    input  logic              mode_load,
    input  logic              run,
    output logic [6:0]        segments,
    output logic [3:0]        frame,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        MODE_COUNT_UP   = 3'd0,
        MODE_COUNT_DOWN = 3'd1,
        MODE_SPIN_CW    = 3'd2,
        MODE_SPIN_CCW   = 3'd3,
        MODE_BOUNCE     = 3'd4,
        MODE_SNAKE      = 3'd5,
        MODE_WIPE       = 3'd6,
        MODE_BLANK      = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [3:0] LAST_DIGIT = 4'(DIGIT_MAX);

    // Standard decimal glyphs; codes above 9 render blank.
    function automatic logic [6:0] glyph(input logic [3:0] digit);
        case (digit)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    // Index of the final frame in each mode's sequence.
    function automatic logic [3:0] last_frame(input mode_e m);
        case (m)
            MODE_COUNT_UP,
            MODE_COUNT_DOWN: last_frame = LAST_DIGIT;
            MODE_SPIN_CW,
            MODE_SPIN_CCW,
            MODE_SNAKE:      last_frame = 4'd5;
            MODE_BOUNCE,
            MODE_WIPE:       last_frame = 4'd6;
            default:         last_frame = 4'd0;
        endcase
    endfunction

    // Segment pattern shown for a given mode and frame index.
    function automatic logic [6:0] pattern(input mode_e m, input logic [3:0] f);
        logic [6:0] p;
        p = 7'h00;
        case (m)
            MODE_COUNT_UP:   p = glyph(f);
            MODE_COUNT_DOWN: p = glyph(LAST_DIGIT - f);
            MODE_SPIN_CW: begin
                case (f)
                    4'd0:    p = 7'h01;
                    4'd1:    p = 7'h02;
                    4'd2:    p = 7'h04;
                    4'd3:    p = 7'h08;
                    4'd4:    p = 7'h10;
                    4'd5:    p = 7'h20;
                    default: p = 7'h00;
                endcase
            end
            MODE_SPIN_CCW: begin
                case (f)
                    4'd0:    p = 7'h01;
                    4'd1:    p = 7'h20;
                    4'd2:    p = 7'h10;
                    4'd3:    p = 7'h08;
                    4'd4:    p = 7'h04;
                    4'd5:    p = 7'h02;
                    default: p = 7'h00;
                endcase
            end
            MODE_BOUNCE: begin
                case (f)
                    4'd0:    p = 7'h41;
                    4'd1:    p = 7'h22;
                    4'd2:    p = 7'h14;
                    4'd3:    p = 7'h08;
                    4'd4:    p = 7'h14;
                    4'd5:    p = 7'h22;
                    4'd6:    p = 7'h41;
                    default: p = 7'h00;
                endcase
            end
            MODE_SNAKE: begin
                case (f)
                    4'd0:    p = 7'h0C;
                    4'd1:    p = 7'h06;
                    4'd2:    p = 7'h03;
                    4'd3:    p = 7'h21;
                    4'd4:    p = 7'h30;
                    4'd5:    p = 7'h18;
                    default: p = 7'h00;
                endcase
            end
            MODE_WIPE: begin
                case (f)
                    4'd0:    p = 7'h41;
                    4'd1:    p = 7'h22;
                    4'd2:    p = 7'h14;
                    4'd3:    p = 7'h08;
                    4'd4:    p = 7'h04;
                    4'd5:    p = 7'h02;
                    4'd6:    p = 7'h01;
                    default: p = 7'h00;
                endcase
            end
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    state_e            state_q,   state_d;
    mode_e             mode_q,    mode_d;
    logic              oneshot_q, oneshot_d;
    logic [TICK_W-1:0] presc_q,   presc_d;
    logic [3:0]        frame_q,   frame_d;
    logic [6:0]        seg_q,     seg_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    // A period of 0 behaves like 1, so the reload value saturates at 0.
    logic [TICK_W-1:0] reload;
    assign reload = (period == '0) ? '0 : period - TICK_W'(1);

    // Next-state logic: mode_load wins over everything, then prescaler tick, then run level.
    always_comb begin
        // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
        state_d   = state_q;
        mode_d    = mode_q;
        oneshot_d = oneshot_q;
        presc_d   = presc_q;
        frame_d   = frame_q;
        done_d    = 1'b0;

        if (mode_load) begin
            mode_d    = mode_e'(mode);
            oneshot_d = oneshot;
            frame_d   = 4'd0;
            presc_d   = reload;
            state_d   = run ? ST_RUN : ST_HOLD;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (presc_q == '0) begin
                        presc_d = reload;
                        if (frame_q == last_frame(mode_q)) begin
                            if (oneshot_q) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                frame_d = 4'd0;
                            end
                        end else begin
                            frame_d = frame_q + 4'd1;
                        end
                    end else begin
                        presc_d = presc_q - TICK_W'(1);
                    end
                    // The count for this cycle still applies; pause takes effect afterwards.
                    if (!run && state_d == ST_RUN) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (run) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
        seg_d  = (state_d == ST_IDLE) ? 7'h00 : pattern(mode_d, frame_d);
    end

    // State and output registers; reset clears the display without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_COUNT_UP;
            oneshot_q <= 1'b0;
            presc_q   <= '0;
            frame_q   <= 4'd0;
            seg_q     <= 7'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            mode_q    <= mode_d;
            oneshot_q <= oneshot_d;
            presc_q   <= presc_d;
            frame_q   <= frame_d;
            seg_q     <= seg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign segments = seg_q;
    assign frame    = frame_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_seg7_anim_engine.sv
// Testbench for seg7_anim_engine: two instances (DIGIT_MAX 9 and 12) share
// the stimulus and are compared every cycle against a frame-table model.
module tb_seg7_anim_engine;

    localparam int TICK_W = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic [TICK_W-1:0] period;
    logic [2:0]        mode;
    logic              oneshot;
    logic              mode_load;
    logic              run;

    logic [6:0] seg_a, seg_b;
    logic [3:0] frame_a, frame_b;
    logic       busy_a, busy_b, done_a, done_b;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen_a = 0;

    always #5 clk = ~clk;

    seg7_anim_engine #(.TICK_W(TICK_W), .DIGIT_MAX(9)) dut_a (
        .clk(clk), .rst(rst), .period(period), .mode(mode), .oneshot(oneshot),
        .mode_load(mode_load), .run(run), .segments(seg_a), .frame(frame_a),
        .busy(busy_a), .done(done_a)
    );

    seg7_anim_engine #(.TICK_W(TICK_W), .DIGIT_MAX(12)) dut_b (
        .clk(clk), .rst(rst), .period(period), .mode(mode), .oneshot(oneshot),
        .mode_load(mode_load), .run(run), .segments(seg_b), .frame(frame_b),
        .busy(busy_b), .done(done_b)
    );

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

    typedef struct {
        int st;
        int md;
        bit os;
        int frm;
        int cnt;   // cycles counted in the current frame
        int per;   // frame length in cycles, captured at each reload
        bit dn;
    } mdl_t;

    mdl_t ma, mb;

    logic [6:0] digit_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    logic [6:0] cw_tbl     [6]  = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20};
    logic [6:0] ccw_tbl    [6]  = '{7'h01, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02};
    logic [6:0] bounce_tbl [7]  = '{7'h41, 7'h22, 7'h14, 7'h08, 7'h14, 7'h22, 7'h41};
    logic [6:0] snake_tbl  [6]  = '{7'h0C, 7'h06, 7'h03, 7'h21, 7'h30, 7'h18};
    logic [6:0] wipe_tbl   [7]  = '{7'h41, 7'h22, 7'h14, 7'h08, 7'h04, 7'h02, 7'h01};

    function automatic int seq_len(input int m, input int dmax);
        case (m)
            0, 1:    return dmax + 1;
            2, 3, 5: return 6;
            4, 6:    return 7;
            default: return 1;
        endcase
    endfunction

    function automatic logic [6:0] exp_pattern(input int m, input int f, input int dmax);
        case (m)
            0:       return digit_tbl[f];
            1:       return digit_tbl[dmax - f];
            2:       return cw_tbl[f];
            3:       return ccw_tbl[f];
            4:       return bounce_tbl[f];
            5:       return snake_tbl[f];
            6:       return wipe_tbl[f];
            default: return 7'h00;
        endcase
    endfunction

    function automatic int eff_period();
        return (period == '0) ? 1 : int'(period);
    endfunction

    function automatic mdl_t model_reset();
        mdl_t s;
        s.st = M_IDLE; s.md = 0; s.os = 1'b0; s.frm = 0; s.cnt = 0; s.per = 1; s.dn = 1'b0;
        return s;
    endfunction

    // One clock edge of behaviour, using the inputs present before the edge.
    function automatic mdl_t model_next(input mdl_t s, input int dmax);
        mdl_t n;
        n = s;
        n.dn = 1'b0;
        if (rst) return model_reset();
        if (mode_load) begin
            n.md  = int'(mode);
            n.os  = oneshot;
            n.frm = 0;
            n.cnt = 0;
            n.per = eff_period();
            n.st  = run ? M_RUN : M_HOLD;
            return n;
        end
        if (s.st == M_RUN) begin
            n.cnt = s.cnt + 1;
            if (n.cnt == s.per) begin
                n.cnt = 0;
                n.per = eff_period();
                if (s.frm == seq_len(s.md, dmax) - 1) begin
                    if (s.os) begin
                        n.st = M_DONE;
                        n.dn = 1'b1;
                    end else begin
                        n.frm = 0;
                    end
                end else begin
                    n.frm = s.frm + 1;
                end
            end
            if (!run && n.st == M_RUN) n.st = M_HOLD;
        end else if (s.st == M_HOLD) begin
            if (run) n.st = M_RUN;
        end
        return n;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [6:0] ea, eb;
        ea = (ma.st == M_IDLE) ? 7'h00 : exp_pattern(ma.md, ma.frm, 9);
        eb = (mb.st == M_IDLE) ? 7'h00 : exp_pattern(mb.md, mb.frm, 12);
        check("seg_a",   32'(seg_a),   32'(ea));
        check("frame_a", 32'(frame_a), 32'(ma.frm));
        check("busy_a",  32'(busy_a),  32'(ma.st == M_RUN || ma.st == M_HOLD));
        check("done_a",  32'(done_a),  32'(ma.dn));
        check("seg_b",   32'(seg_b),   32'(eb));
        check("frame_b", 32'(frame_b), 32'(mb.frm));
        check("busy_b",  32'(busy_b),  32'(mb.st == M_RUN || mb.st == M_HOLD));
        check("done_b",  32'(done_b),  32'(mb.dn));
        if (done_a) done_seen_a++;
    endtask

    // One clock: advance the model at the edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        ma = model_next(ma, 9);
        mb = model_next(mb, 12);
        @(negedge clk);
        compare_all();
    endtask

    task automatic load(input int m, input bit os, input int per, input bit r);
        mode      = 3'(m);
        oneshot   = os;
        period    = TICK_W'(per);
        run       = r;
        mode_load = 1'b1;
        cycle();
        mode_load = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; period = '0; mode = '0; oneshot = 1'b0; mode_load = 1'b0; run = 1'b0;
        ma = model_reset();
        mb = model_reset();
        repeat (2) cycle();
        rst = 1'b0;

        // Idle after reset: run toggling alone must not start anything.
        for (int i = 0; i < 6; i++) begin
            run = i[0];
            cycle();
        end

        // Count up, period 3, looping through a full wrap.
        load(0, 1'b0, 3, 1'b1);
        repeat (36) cycle();

        // Asynchronous reset in the middle of RUN, checked before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("async_seg",   32'(seg_a),  32'h00);
        check("async_frame", 32'(frame_a), 32'h0);
        check("async_busy",  32'(busy_a), 32'h0);
        check("async_seg_b", 32'(seg_b),  32'h00);
        ma = model_reset();
        mb = model_reset();
        repeat (2) cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run = ~run;
            cycle();
        end

        // SPIN_CW one-shot at period 0: one frame per cycle, single done pulse.
        done_seen_a = 0;
        load(2, 1'b1, 0, 1'b1);
        repeat (10) cycle();
        check("spin_final_seg",  32'(seg_a),  32'h20);
        check("spin_final_busy", 32'(busy_a), 32'h0);
        check("spin_done_count", 32'(done_seen_a), 32'd1);

        // BOUNCE pause: drop run one cycle into frame 2, hold 10 cycles, resume.
        load(4, 1'b0, 4, 1'b1);
        repeat (9) cycle();
        run = 1'b0;
        repeat (10) cycle();
        check("pause_held_seg", 32'(seg_a), 32'h14);
        run = 1'b1;
        repeat (2) cycle();
        check("resume_pre_seg", 32'(seg_a), 32'h14);
        cycle();
        check("resume_seg", 32'(seg_a), 32'h08);
        repeat (6) cycle();

        // mode_load to SNAKE lands on the same edge as a WIPE tick.
        load(6, 1'b0, 2, 1'b1);
        cycle();
        load(5, 1'b0, 2, 1'b1);
        check("snake_seg",   32'(seg_a),   32'h0C);
        check("snake_frame", 32'(frame_a), 32'h0);
        repeat (4) cycle();

        // COUNT_DOWN: the 12-digit instance opens with three blank frames.
        load(1, 1'b0, 1, 1'b1);
        check("cd12_first_seg", 32'(seg_b), 32'h00);
        check("cd9_first_seg",  32'(seg_a), 32'h6F);
        repeat (30) cycle();

        // BLANK one-shot, L = 1: done after exactly P cycles.
        load(7, 1'b1, 3, 1'b1);
        repeat (5) cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end else if ($urandom_range(0, 11) == 0) begin
                load(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 4)), 1'($urandom_range(0, 3) != 0));
            end else begin
                if ($urandom_range(0, 7) == 0) run = ~run;
                if ($urandom_range(0, 15) == 0) period = TICK_W'($urandom_range(0, 4));
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_anim_engine.md
# seg7_anim_engine

Parametrised, clocked frame sequencer for a single 7-segment digit. It generalises the fixed combinational digit decoder and the pattern tables into one block with eight selectable modes, a programmable frame period, looping or one-shot playback, pause, and a done pulse. It sits between the top-level control inputs and the segment output pins and replaces the per-animation decoders.

## Interface

Parameters:
- `TICK_W`, default 24: width of the frame-period prescaler and of `period`.
- `DIGIT_MAX`, default 9: last digit shown in count modes (1..15). Digits 10..15 display blank.

Ports:
- `clk`, input, 1: single clock domain.
- `rst`, input, 1: asynchronous reset, active-high.
- `period`, input, TICK_W: clock cycles per frame. 0 is treated as 1.
- `mode`, input, 3: pattern select. Sampled only on `mode_load`.
- `oneshot`, input, 1: 1 = play the sequence once, 0 = loop. Sampled on `mode_load`.
- `mode_load`, input, 1: one-cycle strobe that latches `mode`/`oneshot` and restarts playback.
- `run`, input, 1: level signal. 1 = advance frames, 0 = hold the current frame.
- `segments`, output, 7: bit0 = top, bit1 = upper-right, bit2 = lower-right, bit3 = bottom, bit4 = lower-left, bit5 = upper-left, bit6 = middle. 1 = lit.
- `frame`, output, 4: current frame index.
- `busy`, output, 1: high in RUN and HOLD.
- `done`, output, 1: one-cycle pulse when a one-shot sequence completes.

## Operation

Modes, with length L and frames given in segment bit order:
- 0 COUNT_UP: L = DIGIT_MAX+1. Shows digits 0..DIGIT_MAX with standard glyphs: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
- 1 COUNT_DOWN: L = DIGIT_MAX+1. Same glyphs, showing digit DIGIT_MAX−frame.
- 2 SPIN_CW: L = 6. Frames 01, 02, 04, 08, 10, 20.
- 3 SPIN_CCW: L = 6. Frames 01, 20, 10, 08, 04, 02.
- 4 BOUNCE: L = 7. Frames 41, 22, 14, 08, 14, 22, 41.
- 5 SNAKE: L = 6. Frames 0C, 06, 03, 21, 30, 18.
- 6 WIPE: L = 7. Frames 41, 22, 14, 08, 04, 02, 01.
- 7 BLANK: L = 1. Frame 00.

State machine with states IDLE, RUN, HOLD, DONE:
- IDLE: `segments` = 0, `busy` = 0. `mode_load` moves to RUN if `run` = 1, otherwise to HOLD.
- RUN: the prescaler counts down and a tick occurs when it reaches 0, after which it reloads to max(period,1)−1. Each tick advances `frame`.
  - At `frame` = L−1 with `oneshot` = 0, `frame` wraps to 0.
  - At `frame` = L−1 with `oneshot` = 1, the block holds the last frame, moves to DONE and pulses `done`.
  - `run` = 0 moves to HOLD.
- HOLD: the prescaler and `frame` are frozen and `segments` keeps its value. `run` = 1 returns to RUN, resuming the remaining prescaler count.
- DONE: the last frame stays displayed and `busy` = 0. Only `mode_load` leaves DONE.
- `mode_load` in any state:
  - latches `mode` and `oneshot`;
  - sets `frame` to 0;
  - loads the prescaler with max(period,1)−1;
  - enters RUN or HOLD according to `run`.
- Simultaneous events:
  - `mode_load` overrides a tick and overrides `run` = 0 in the same cycle.
  - A tick and `run` falling in the same cycle: the tick is applied, then the block enters HOLD.
- `period` changes take effect at the next reload only.

## Timing

- Reset values: state IDLE, latched mode 0, latched oneshot 0, prescaler 0, `frame` 0, `segments` 0, `busy` 0, `done` 0.
- All outputs are registered. `segments` and `frame` update on the same edge.
- After a `mode_load` at edge N, `frame` = 0 and the frame-0 pattern appear after edge N.
- With a constant `period` P ≥ 1 in RUN, frame k begins P·k cycles after the load edge.
- `done` is asserted for exactly one cycle, on the same edge that the block enters DONE. For L = 1 this happens after P cycles.
- Asserting `rst` mid-sequence clears all outputs immediately, without waiting for a clock edge.

## Test plan

- Reset: assert `rst` mid-RUN → `segments` = 00, `frame` = 0, `busy` = 0 asynchronously. After release the block stays in IDLE with no toggling.
- Count up, DIGIT_MAX = 9, period = 3, loop → `segments` steps 3F, 06, 5B … 6F and then back to 3F, with `frame` changing every 3 cycles. `done` never fires.
- SPIN_CW, one-shot, period = 0 → one frame per cycle: 01, 02, 04, 08, 10, 20. `done` pulses once, `segments` holds 20, `busy` = 0.
- Pause: BOUNCE with period = 4; drop `run` after frame 2 plus 1 cycle, hold it low 10 cycles, then raise it → 14 is held throughout and 08 appears 3 cycles after `run` rises.
- `mode_load` to SNAKE issued in the same cycle as a WIPE tick → next `segments` = 0C, `frame` = 0, and no WIPE advance occurs.
- DIGIT_MAX = 12, COUNT_DOWN → the first three frames are blank (00), then 6F, 7F … 3F, then wrap.
